seg_scan_driver: RTL and testbench

Eight-digit multiplexed 7-segment display driver for the board's shared-cathode-bus display (segments CA..CG plus DP, anodes AN0..AN7, all active-low). It takes a 32-bit hex word from the core logic through a load strobe and scans it across all eight digits with per-slot anti-ghosting blanking. It is the display-side consumer for every counter and register in the design that currently drives only a single digit.

---
 rtl/seg_pkg.sv | 46 ++++
 rtl/seg_hex_decode.sv | 16 +
 rtl/seg_scan_driver.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 7-segment display blocks.
//   NUM_DIGITS  - digits on the multiplexed display
//   SEG_BLANK   - active-low "all segments off" pattern
//   SEG_TABLE   - 16-entry active-low hex glyph table, bit order {G,F,E,D,C,B,A}
//   nibble_t    - one hex digit
//   disp_word_t - a full display image: eight nibbles plus eight decimal points
//   hex_to_seg  - table lookup helper, usable by single-digit consumers too
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIBBLE_W   = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index 15 is listed first so SEG_TABLE[n] yields the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef struct packed {
    logic [NUM_DIGITS*NIBBLE_W-1:0] data;
    logic [NUM_DIGITS-1:0]          dp;
  } disp_word_t;

  function automatic logic [6:0] hex_to_seg(input nibble_t n);
    return SEG_TABLE[n];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nibble_i  in  4  hex digit 0..F
//   seg_o     out 7  active-low segments, bit order {G,F,E,D,C,B,A}
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: eight-digit multiplexed 7-segment display driver.
//
// A 32-bit hex word (plus eight decimal points) is captured on LOAD into a
// pending image and promoted to the displayed image only at a frame boundary,
// so one scan frame never mixes old and new values. Each digit slot lasts
// SCAN_DIV cycles; the first BLANK_CYCLES of a slot keep every anode and
// segment off to suppress ghosting between digits. All outputs are registered.
//
// Parameters:
//   SCAN_DIV      cycles per digit slot (>= 2)
//   BLANK_CYCLES  blanked cycles at the start of each slot (< SCAN_DIV)
// Ports:
//   CLK            in   system clock
//   RST            in   synchronous active-high reset
//   DATA[31:0]     in   nibble i drives digit i (AN0 = rightmost)
//   DP_IN[7:0]     in   decimal point per digit, 1 = lit
//   LOAD           in   one-cycle capture strobe for DATA/DP_IN
//   BUSY           out  a captured value is waiting for the frame boundary
//   CA..CG, CDP    out  segments and decimal point, active-low
//   AN0..AN7       out  anodes, active-low, at most one low at a time
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits 1..7 whose nibble and every
//                          higher nibble are zero (and whose DP is off) show
//                          no segments; digit 0 is always shown.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP_IN,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        CDP,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic        AN4,
  output logic        AN5,
  output logic        AN6,
  output logic        AN7
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0] PreLast  = PreW'(SCAN_DIV - 1);
  localparam logic [PreW-1:0] PreBlank = PreW'(BLANK_CYCLES);

  // Scan timing
  logic [PreW-1:0] pre_q, pre_d;
  logic [2:0]      idx_q, idx_d;
  logic            tick;
  logic            frame;

  // Two-stage image path
  disp_word_t pend_q, pend_d;
  disp_word_t disp_q, disp_d;
  logic       busy_q, busy_d;

  // Output registers
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  cdp_q, cdp_d;

  // Current digit decode
  nibble_t               cur_nib;
  logic [6:0]            cur_seg;
  logic                  slot_lit;
  logic [NUM_DIGITS-1:0] lz_blank;

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  assign tick  = (pre_q == PreLast);
  assign frame = tick && (idx_q == 3'd7);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PreW'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;
  end

  // ---------------------------------------------------------------------------
  // Load path: LOAD always refreshes the pending image. A LOAD on the frame
  // cycle bypasses straight to the display image, otherwise the pending image
  // is promoted at the next frame boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    disp_d = disp_q;
    busy_d = busy_q;
    if (LOAD) begin
      pend_d = '{data: DATA, dp: DP_IN};
      if (frame) begin
        disp_d = '{data: DATA, dp: DP_IN};
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (frame && busy_q) begin
      disp_d = pend_q;
      busy_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode
  // ---------------------------------------------------------------------------
  assign cur_nib = disp_q.data[{idx_q, 2'b00} +: NIBBLE_W];

  seg_hex_decode u_hex_decode (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down: a digit is a leading zero
  // while it and every digit above it hold zero. Digit 0 always shows.
  logic upper_zero;

  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (disp_q.data[i*NIBBLE_W +: NIBBLE_W] == '0);
      lz_blank[i] = upper_zero & ~disp_q.dp[i];
    end
  end
`else
  assign lz_blank = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output next-state: the anode stays off for the first BLANK_CYCLES of each
  // slot, and segments are forced off whenever no anode is driven.
  // ---------------------------------------------------------------------------
  assign slot_lit = (pre_q >= PreBlank);

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    cdp_d = 1'b1;
    if (slot_lit) begin
      an_d[idx_q] = 1'b0;
      if (!lz_blank[idx_q]) begin
        seg_d = cur_seg;
        cdp_d = ~disp_q.dp[idx_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      disp_q <= '0;
      busy_q <= 1'b0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      cdp_q  <= 1'b1;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      busy_q <= busy_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      cdp_q  <= cdp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin mapping
  // ---------------------------------------------------------------------------
  assign BUSY = busy_q;
  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign CDP = cdp_q;
  assign AN0 = an_q[0];
  assign AN1 = an_q[1];
  assign AN2 = an_q[2];
  assign AN3 = an_q[3];
  assign AN4 = an_q[4];
  assign AN5 = an_q[5];
  assign AN6 = an_q[6];
  assign AN7 = an_q[7];

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with SCAN_DIV = 4, BLANK_CYCLES = 1.
// A frame-position model (cycle count since reset, divided into slots and
// frames) predicts every registered output each cycle; directed scenarios
// pin the model with literal glyphs, then a randomized phase follows.
module tb_seg_scan_driver;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * SD;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b1;
  logic        LOAD  = 1'b0;
  logic [31:0] DATA  = '0;
  logic [7:0]  DP_IN = '0;
  logic BUSY, CA, CB, CC, CD, CE, CF, CG, CDP;
  logic AN0, AN1, AN2, AN3, AN4, AN5, AN6, AN7;

  logic [7:0] an;
  logic [6:0] seg;
  assign an  = {AN7, AN6, AN5, AN4, AN3, AN2, AN1, AN0};
  assign seg = {CG, CF, CE, CD, CC, CB, CA};

  seg_scan_driver #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DATA  (DATA),
    .DP_IN (DP_IN),
    .LOAD  (LOAD),
    .BUSY  (BUSY),
    .CA    (CA),
    .CB    (CB),
    .CC    (CC),
    .CD    (CD),
    .CE    (CE),
    .CF    (CF),
    .CG    (CG),
    .CDP   (CDP),
    .AN0   (AN0),
    .AN1   (AN1),
    .AN2   (AN2),
    .AN3   (AN3),
    .AN4   (AN4),
    .AN5   (AN5),
    .AN6   (AN6),
    .AN7   (AN7)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic bit lz_digit(input int idx, input logic [31:0] d, input logic [7:0] dp);
    bit en;
`ifdef LEADING_ZERO_BLANK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && idx > 0 && (d >> (4 * idx)) == 32'd0 && !dp[idx];
  endfunction

  function automatic bit is_frame(input int tv);
    return (tv % FRAME) == FRAME - 1;
  endfunction

  // {anodes, segments, dp} for the cycle tv cycles after reset release.
  function automatic logic [15:0] exp_out(input int tv, input logic [31:0] d,
                                          input logic [7:0] dp);
    int pre, idx;
    logic [7:0] a;
    logic [6:0] s;
    logic c;
    pre = tv % SD;
    idx = (tv / SD) % 8;
    a = 8'hFF;
    s = 7'h7F;
    c = 1'b1;
    if (pre >= BC) begin
      a[idx] = 1'b0;
      if (!lz_digit(idx, d, dp)) begin
        s = glyph(4'((d >> (4 * idx)) & 32'hF));
        c = ~dp[idx];
      end
    end
    return {a, s, c};
  endfunction

  int          t       = 0;
  logic [31:0] m_pd    = '0, m_dd = '0;
  logic [7:0]  m_pp    = '0, m_dpp = '0;
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic [7:0]  e_an    = 8'hFF;
  logic [6:0]  e_seg   = 7'h7F;
  logic        e_dp    = 1'b1;

  always @(posedge CLK) begin
    if (RST) begin
      t       <= 0;
      m_pd    <= '0;
      m_pp    <= '0;
      m_dd    <= '0;
      m_dpp   <= '0;
      m_busy  <= 1'b0;
      {e_an, e_seg, e_dp} <= {8'hFF, 7'h7F, 1'b1};
      m_valid <= 1'b1;
    end else begin
      {e_an, e_seg, e_dp} <= exp_out(t, m_dd, m_dpp);
      t <= t + 1;
      if (LOAD) begin
        m_pd <= DATA;
        m_pp <= DP_IN;
        if (is_frame(t)) begin
          m_dd   <= DATA;
          m_dpp  <= DP_IN;
          m_busy <= 1'b0;
        end else begin
          m_busy <= 1'b1;
        end
      end else if (is_frame(t) && m_busy) begin
        m_dd   <= m_pd;
        m_dpp  <= m_pp;
        m_busy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, plus a record of what each digit showed
  // ---------------------------------------------------------------------------
  logic [6:0] seen   [8];
  int         lowcnt [8];

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("anodes", 32'(an), 32'(e_an));
      chk("segments", 32'(seg), 32'(e_seg));
      chk("cdp", 32'(CDP), 32'(e_dp));
      chk("busy", 32'(BUSY), 32'(m_busy));
      chk("one_anode_max", 32'($countones(~an) <= 1), 32'd1);
      for (int k = 0; k < 8; k++) begin
        if (an[k] === 1'b0) begin
          seen[k]   = seg;
          lowcnt[k] = lowcnt[k] + 1;
        end
      end
    end
  end

  task automatic clear_seen();
    for (int k = 0; k < 8; k++) begin
      seen[k]   = 7'h55;
      lowcnt[k] = 0;
    end
  endtask

  // Advance to the next negedge where the model's frame position equals p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((t % FRAME) != p && n < FRAME + 8);
    if ((t % FRAME) != p) begin
      total++;
      bad++;
      $display("FAIL wait_phase: got %0d expected %0d", t % FRAME, p);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp);
    DATA  = d;
    DP_IN = dp;
    LOAD  = 1'b1;
    @(negedge CLK);
    LOAD  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [6:0] scan_exp [8];
  logic [6:0] lz_hi;

  initial begin
    scan_exp = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    clear_seen();

    // Reset
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_an", 32'(an), 32'hFF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_cdp", 32'(CDP), 32'h1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("first_an", 32'(an), 32'hFE);
    chk("first_seg", 32'(seg), 32'h40);

    // Scan order
    do_load(32'h89AB_CDEF, 8'h00);
    chk("scan_busy", 32'(BUSY), 32'h1);
    wait_phase(1);
    clear_seen();
    wait_phase(1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan_seg%0d", k), 32'(seen[k]), 32'(scan_exp[k]));
      chk($sformatf("scan_lit%0d", k), 32'(lowcnt[k]), 32'd3);
    end

    // Frame coherence
    clear_seen();
    wait_phase(12);
    do_load(32'h1111_1111, 8'h00);
    chk("coh_busy_set", 32'(BUSY), 32'h1);
    wait_phase(31);
    chk("coh_busy_hold", 32'(BUSY), 32'h1);
    @(negedge CLK);
    chk("coh_busy_clr", 32'(BUSY), 32'h0);
    wait_phase(1);
    for (int k = 4; k < 8; k++) begin
      chk($sformatf("coh_old%0d", k), 32'(seen[k]), 32'(scan_exp[k]));
    end
    clear_seen();
    wait_phase(5);
    chk("coh_new0", 32'(seen[0]), 32'h79);

    // Back-to-back loads: last write wins
    wait_phase(2);
    do_load(32'h2222_2222, 8'h00);
    do_load(32'h3333_3333, 8'h00);
    wait_phase(1);
    clear_seen();
    wait_phase(1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_seg%0d", k), 32'(seen[k]), 32'h30);
    end

    // Load on the frame cycle
    wait_phase(31);
    do_load(32'h4455_6677, 8'h00);
    chk("coin_busy", 32'(BUSY), 32'h0);
    wait_phase(1);
    clear_seen();
    wait_phase(1);
    chk("coin_seg0", 32'(seen[0]), 32'h78);
    chk("coin_seg7", 32'(seen[7]), 32'h19);

    // Reset mid-operation with a pending value
    wait_phase(16);
    do_load(32'hDEAD_BEEF, 8'hA5);
    chk("mid_busy", 32'(BUSY), 32'h1);
    wait_phase(21);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_an", 32'(an), 32'hFF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_cdp", 32'(CDP), 32'h1);
    chk("mid_rst_busy", 32'(BUSY), 32'h0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("restart_an", 32'(an), 32'hFE);
    chk("restart_seg", 32'(seg), 32'h40);

    // Leading-zero handling
    do_load(32'h0000_0420, 8'h00);
    wait_phase(1);
    clear_seen();
    wait_phase(1);
`ifdef LEADING_ZERO_BLANK_EN
    lz_hi = 7'h7F;
`else
    lz_hi = 7'h40;
`endif
    chk("lz_seg0", 32'(seen[0]), 32'h40);
    chk("lz_seg1", 32'(seen[1]), 32'h24);
    chk("lz_seg2", 32'(seen[2]), 32'h19);
    for (int k = 3; k < 8; k++) begin
      chk($sformatf("lz_seg%0d", k), 32'(seen[k]), 32'(lz_hi));
    end

    // Randomized traffic against the model
    repeat (1500) begin
      @(negedge CLK);
      LOAD  = ($urandom_range(0, 7) == 0);
      DATA  = $urandom;
      DP_IN = 8'($urandom);
      RST   = ($urandom_range(0, 399) == 0);
    end
    LOAD = 1'b0;
    RST  = 1'b0;
    repeat (4) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
